// File: rtl/bpred_wrport_ctrl_pkg.sv
// Shared types and helpers for the branch-predictor write-port controller.
package bpred_pkg;

    localparam int IDX_W = 8;

    localparam logic [3:0] BE_BIMODAL_ONLY = 4'b0001;
    localparam logic [3:0] BE_FULL         = 4'b1111;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } wr_state_t;

    // One buffered execute-stage update; the counter is already advanced.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       ctr_next;
        logic             btb_wr;
        logic [29:0]      btb_data;
        logic [8:0]       carry;
    } upd_entry_t;

    localparam int UPD_ENTRY_W = $bits(upd_entry_t);

    // Saturating 2-bit bimodal counter step toward the resolved direction.
    function automatic logic [1:0] sat_ctr_next(input logic dir, input logic [1:0] ctr);
        logic [1:0] res;
        if (dir) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    // Memory word for an update; without a BTB write only the low byte lane is live.
    function automatic logic [35:0] pack_entry(input upd_entry_t e);
        logic [35:0] word;
        if (e.btb_wr) begin
            word = {e.btb_data, e.ctr_next, e.carry[3:0]};
        end else begin
            word = {27'b0, e.carry[8:6], e.ctr_next, e.carry[3:0]};
        end
        return word;
    endfunction

endpackage

// File: rtl/bpred_wrport_ctrl_if.sv
// Update bus, software config port and predictor memory write pins.
interface bpred_wrport_ctrl_if #(
    parameter int IDX_W = bpred_pkg::IDX_W
);
    logic             up_valid;
    logic             stall;
    logic [31:0]      up_pc4;
    logic             up_dir;
    logic [1:0]       up_ctr;
    logic             up_btb_wr;
    logic [29:0]      up_btb_data;
    logic [8:0]       up_carry;

    logic             cfg_req;
    logic [IDX_W-1:0] cfg_index;
    logic [35:0]      cfg_data;
    logic [3:0]       cfg_be;
    logic             cfg_ack;

    logic             flush_req;

    logic             mem_wren;
    logic [IDX_W-1:0] mem_wraddress;
    logic [35:0]      mem_data;
    logic [3:0]       mem_byteena;

    logic             init_busy;
    logic             up_full;
    logic [15:0]      drop_count;

    modport master (
        output up_valid, stall, up_pc4, up_dir, up_ctr, up_btb_wr, up_btb_data, up_carry,
        output cfg_req, cfg_index, cfg_data, cfg_be, flush_req,
        input  cfg_ack, mem_wren, mem_wraddress, mem_data, mem_byteena,
        input  init_busy, up_full, drop_count
    );

    modport slave (
        input  up_valid, stall, up_pc4, up_dir, up_ctr, up_btb_wr, up_btb_data, up_carry,
        input  cfg_req, cfg_index, cfg_data, cfg_be, flush_req,
        output cfg_ack, mem_wren, mem_wraddress, mem_data, mem_byteena,
        output init_busy, up_full, drop_count
    );
endinterface

// File: rtl/bpred_wrport_ctrl_upd_fifo.sv
// Small synchronous FIFO holding execute-stage updates until the port is free.
module bpred_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = bpred_pkg::UPD_ENTRY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop    = pop & ~empty & ~clear;
    assign do_push   = push & (~full | do_pop) & ~clear;
    assign head_data = store[rd_ptr[PTR_W-1:0]];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Entry storage needs no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/bpred_wrport_ctrl.sv
// Write-port controller: clearing sweep, update buffering, cfg arbitration.
module bpred_wrport_ctrl #(
    parameter int IDX_W      = bpred_pkg::IDX_W,
    parameter int FIFO_DEPTH = 4,
    parameter int AGE_LIMIT  = 8
) (
    input  logic               clk,
    input  logic               reset,
    bpred_wrport_ctrl_if.slave bus
);
    import bpred_pkg::*;

    localparam int AGE_W = $clog2(AGE_LIMIT + 1);

    wr_state_t        state, state_nxt;
    logic [IDX_W-1:0] sweep_idx, sweep_idx_nxt;
    logic [AGE_W-1:0] cfg_age;
    logic             age_win;
    logic             sweep_wr;
    logic             grant_fifo;
    logic             grant_cfg;

    logic             fifo_full;
    logic             fifo_empty;
    logic             enq;
    logic             drop_evt;
    upd_entry_t       push_entry;
    upd_entry_t       head_entry;

    logic [15:0]      drop_cnt;
    logic             wren_q;
    logic [IDX_W-1:0] addr_q;
    logic [35:0]      data_q;
    logic [3:0]       be_q;

    logic             unused_pc_bits;
    assign unused_pc_bits = ^{bus.up_pc4[31:IDX_W+2], bus.up_pc4[1:0]};

    assign age_win = (cfg_age >= AGE_W'(AGE_LIMIT));

    // Next state, sweep index and write-port grant for this cycle.
    always_comb begin
        state_nxt     = state;
        sweep_idx_nxt = sweep_idx;
        sweep_wr      = 1'b0;
        grant_fifo    = 1'b0;
        grant_cfg     = 1'b0;
        if (bus.flush_req) begin
            state_nxt     = ST_INIT;
            sweep_idx_nxt = '0;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep_wr      = 1'b1;
                    sweep_idx_nxt = sweep_idx + IDX_W'(1);
                    if (sweep_idx == '1) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.cfg_req && (age_win || fifo_empty)) begin
                        grant_cfg = 1'b1;
                    end else if (!fifo_empty) begin
                        grant_fifo = 1'b1;
                    end
                end
                default: state_nxt = ST_INIT;
            endcase
        end
    end

    // State register and sweep position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
        end else begin
            state     <= state_nxt;
            sweep_idx <= sweep_idx_nxt;
        end
    end

    // Build the buffered entry; the counter step happens before queuing.
    always_comb begin
        push_entry          = '0;
        push_entry.idx      = bus.up_pc4[IDX_W+1:2];
        push_entry.ctr_next = sat_ctr_next(bus.up_dir, bus.up_ctr);
        push_entry.btb_wr   = bus.up_btb_wr;
        push_entry.btb_data = bus.up_btb_data;
        push_entry.carry    = bus.up_carry;
    end

    // A full FIFO still accepts when its head leaves in the same cycle.
    assign enq      = bus.up_valid & ~bus.stall & ~bus.flush_req & (~fifo_full | grant_fifo);
    assign drop_evt = bus.up_valid & ~bus.stall & ~bus.flush_req & fifo_full & ~grant_fifo;

    bpred_upd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UPD_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (bus.flush_req),
        .push      (enq),
        .push_data (push_entry),
        .pop       (grant_fifo),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Age of a losing cfg request; saturates at the limit, clears on grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_age <= '0;
        end else if (grant_cfg) begin
            cfg_age <= '0;
        end else if (bus.cfg_req && !age_win) begin
            cfg_age <= cfg_age + AGE_W'(1);
        end
    end

    // Saturating count of updates lost to a full buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop_evt && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Registered write port, loaded from whichever source won this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wren_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            be_q   <= '0;
        end else begin
            wren_q <= sweep_wr | grant_fifo | grant_cfg;
            if (sweep_wr) begin
                addr_q <= sweep_idx;
                data_q <= '0;
                be_q   <= BE_FULL;
            end else if (grant_fifo) begin
                addr_q <= head_entry.idx;
                data_q <= pack_entry(head_entry);
                be_q   <= head_entry.btb_wr ? BE_FULL : BE_BIMODAL_ONLY;
            end else if (grant_cfg) begin
                addr_q <= bus.cfg_index;
                data_q <= bus.cfg_data;
                be_q   <= bus.cfg_be;
            end
        end
    end

    assign bus.mem_wren      = wren_q;
    assign bus.mem_wraddress = addr_q;
    assign bus.mem_data      = data_q;
    assign bus.mem_byteena   = be_q;
    assign bus.cfg_ack       = grant_cfg;
    assign bus.init_busy     = (state == ST_INIT);
    assign bus.up_full       = fifo_full;
    assign bus.drop_count    = drop_cnt;

endmodule

// File: tb/tb_bpred_wrport_ctrl.sv
// Directed self-checking bench for the predictor write-port controller.
module tb_bpred_wrport_ctrl;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    bpred_wrport_ctrl_if #(.IDX_W(8)) bus ();

    bpred_wrport_ctrl #(
        .IDX_W      (8),
        .FIFO_DEPTH (4),
        .AGE_LIMIT  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc4, input logic dir,
                                 input logic [1:0] ctr, input logic btb_wr,
                                 input logic [29:0] btb_data, input logic [8:0] carry);
        bus.up_valid    = valid;
        bus.up_pc4      = pc4;
        bus.up_dir      = dir;
        bus.up_ctr      = ctr;
        bus.up_btb_wr   = btb_wr;
        bus.up_btb_data = btb_data;
        bus.up_carry    = carry;
    endtask

    // Starts at the sample point of the cycle that should show write 0.
    task automatic sweepCheck(input string tag);
        int   nbad;
        logic busy254;
        nbad    = 0;
        busy254 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) begin
                step();
                @(negedge clk);
            end
            if (!(bus.mem_wren === 1'b1 && bus.mem_wraddress === 8'(i) &&
                  bus.mem_data === 36'h0 && bus.mem_byteena === 4'hF)) nbad++;
            if (i == 254) busy254 = bus.init_busy;
        end
        checkOutput({tag, "_bad_writes"}, 64'(nbad), 64'd0);
        checkOutput({tag, "_busy_mid"}, busy254, 1);
        step();
        @(negedge clk);
        checkOutput({tag, "_busy_after"}, bus.init_busy, 0);
        checkOutput({tag, "_no_extra_wr"}, bus.mem_wren, 0);
        step();
    endtask

    task automatic waitWrite(input int maxc, output logic found);
        found = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            if (bus.mem_wren === 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic waitAddr(input logic [7:0] addr, input int maxc, output logic found);
        found = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            if (bus.mem_wren === 1'b1 && bus.mem_wraddress === addr) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic runVector(input string tag, input logic [31:0] pc4, input logic dir,
                             input logic [1:0] ctr, input logic btb_wr, input logic [29:0] btb_data,
                             input logic [8:0] carry, input logic [7:0] exp_addr,
                             input logic [35:0] exp_data, input logic [3:0] exp_be);
        applyStimulus(1'b1, pc4, dir, ctr, btb_wr, btb_data, carry);
        step();
        bus.up_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_early"}, bus.mem_wren, 0);
        step();
        @(negedge clk);
        checkOutput({tag, "_wren"}, bus.mem_wren, 1);
        checkOutput({tag, "_addr"}, bus.mem_wraddress, exp_addr);
        checkOutput({tag, "_data"}, bus.mem_data, exp_data);
        checkOutput({tag, "_be"}, bus.mem_byteena, exp_be);
        step();
    endtask

    logic [31:0] fill_pc   [5] = '{32'h010, 32'h014, 32'h018, 32'h01C, 32'h020};
    logic        fill_dir  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  fill_ctr  [5] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
    logic [8:0]  fill_car  [5] = '{9'h000, 9'h1FF, 9'h003, 9'h040, 9'h000};
    logic [7:0]  fill_addr [4] = '{8'h04, 8'h05, 8'h06, 8'h07};
    logic [35:0] fill_data [4] = '{36'h010, 36'h1DF, 36'h003, 36'h070};

    initial begin
        logic found;
        int   ackn;
        int   nw;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 30'h0, 9'h0);
        bus.stall     = 1'b0;
        bus.cfg_req   = 1'b0;
        bus.cfg_index = 8'h00;
        bus.cfg_data  = 36'h0;
        bus.cfg_be    = 4'h0;
        bus.flush_req = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_wren", bus.mem_wren, 0);
        checkOutput("rst_addr", bus.mem_wraddress, 0);
        checkOutput("rst_data", bus.mem_data, 0);
        checkOutput("rst_be", bus.mem_byteena, 0);
        checkOutput("rst_ack", bus.cfg_ack, 0);
        checkOutput("rst_full", bus.up_full, 0);
        checkOutput("rst_drop", bus.drop_count, 0);
        checkOutput("rst_busy", bus.init_busy, 1);

        // Initial clearing sweep right after reset release.
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        @(negedge clk);
        sweepCheck("init_sweep");

        // Counter update and packing vectors.
        runVector("v_taken01", 32'h104, 1'b1, 2'b01, 1'b0, 30'h0, 9'h1C5, 8'h41, 36'h1E5, 4'b0001);
        runVector("v_nt00", 32'h200, 1'b0, 2'b00, 1'b0, 30'h0, 9'h0AA, 8'h80, 36'h08A, 4'b0001);
        runVector("v_t11_btb", 32'h3FC, 1'b1, 2'b11, 1'b1, 30'h12345678, 9'h00F, 8'hFF,
                  36'h48D159E3F, 4'b1111);
        runVector("v_nt11", 32'h008, 1'b0, 2'b11, 1'b0, 30'h0, 9'h140, 8'h02, 36'h160, 4'b0001);
        runVector("v_nt01_btb", 32'h7F0, 1'b0, 2'b01, 1'b1, 30'h3FFFFFFF, 9'h1F3, 8'hFC,
                  36'hFFFFFFFC3, 4'b1111);

        // A stalled update is never queued.
        applyStimulus(1'b1, 32'h0C0, 1'b1, 2'b00, 1'b0, 30'h0, 9'h0);
        bus.stall = 1'b1;
        step();
        step();
        @(negedge clk);
        checkOutput("stall_no_wr", bus.mem_wren, 0);
        checkOutput("stall_no_drop", bus.drop_count, 0);
        bus.up_valid = 1'b0;
        bus.stall    = 1'b0;
        step();

        // Lone cfg request is granted at once.
        bus.cfg_req   = 1'b1;
        bus.cfg_index = 8'h5A;
        bus.cfg_data  = 36'h012345678;
        bus.cfg_be    = 4'b1000;
        @(negedge clk);
        checkOutput("cfg_idle_ack", bus.cfg_ack, 1);
        step();
        bus.cfg_req = 1'b0;
        @(negedge clk);
        checkOutput("cfg_idle_wren", bus.mem_wren, 1);
        checkOutput("cfg_idle_addr", bus.mem_wraddress, 8'h5A);
        checkOutput("cfg_idle_data", bus.mem_data, 36'h012345678);
        checkOutput("cfg_idle_be", bus.mem_byteena, 4'b1000);
        checkOutput("cfg_idle_ack_off", bus.cfg_ack, 0);
        step();

        // Aged cfg request eventually beats a busy update stream.
        applyStimulus(1'b1, 32'h300, 1'b1, 2'b01, 1'b0, 30'h0, 9'h0);
        step();
        bus.cfg_req   = 1'b1;
        bus.cfg_index = 8'h33;
        bus.cfg_data  = 36'h9ABCDEF01;
        bus.cfg_be    = 4'b0110;
        ackn = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.cfg_ack === 1'b1) begin
                ackn = n;
                break;
            end
            step();
        end
        checkOutput("age_ack_cycle", 64'(ackn), 64'd9);
        step();
        bus.cfg_req  = 1'b0;
        bus.up_valid = 1'b0;
        @(negedge clk);
        checkOutput("age_cfg_addr", bus.mem_wraddress, 8'h33);
        checkOutput("age_cfg_data", bus.mem_data, 36'h9ABCDEF01);
        checkOutput("age_cfg_be", bus.mem_byteena, 4'b0110);
        repeat (4) step();

        // Flush from RUN, then flush again when index 100 is next.
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        waitAddr(8'd99, 300, found);
        checkOutput("flush_reach99", found, 1);
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        waitWrite(4, found);
        checkOutput("flush100_found", found, 1);
        checkOutput("flush100_first_addr", bus.mem_wraddress, 8'd0);
        sweepCheck("flush100_sweep");

        // Fill the buffer during a sweep: fifth update is dropped.
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, fill_pc[k], fill_dir[k], fill_ctr[k], 1'b0, 30'h0, fill_car[k]);
            step();
        end
        bus.up_valid = 1'b0;
        @(negedge clk);
        checkOutput("fill_drop", bus.drop_count, 1);
        checkOutput("fill_full", bus.up_full, 1);
        checkOutput("fill_busy", bus.init_busy, 1);
        step();
        waitAddr(8'd255, 300, found);
        checkOutput("fill_sweep_end", found, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            checkOutput($sformatf("fill%0d_wren", k), bus.mem_wren, 1);
            checkOutput($sformatf("fill%0d_addr", k), bus.mem_wraddress, fill_addr[k]);
            checkOutput($sformatf("fill%0d_data", k), bus.mem_data, fill_data[k]);
            checkOutput($sformatf("fill%0d_be", k), bus.mem_byteena, 4'b0001);
        end
        step();
        @(negedge clk);
        checkOutput("fill_done_wren", bus.mem_wren, 0);
        checkOutput("fill_done_full", bus.up_full, 0);
        checkOutput("fill_done_drop", bus.drop_count, 1);
        step();

        // Asynchronous reset in the middle of a drain.
        applyStimulus(1'b1, 32'h040, 1'b1, 2'b00, 1'b0, 30'h0, 9'h0);
        step();
        applyStimulus(1'b1, 32'h044, 1'b1, 2'b00, 1'b0, 30'h0, 9'h0);
        step();
        applyStimulus(1'b1, 32'h048, 1'b1, 2'b00, 1'b0, 30'h0, 9'h0);
        checkOutput("mid_wren_before", bus.mem_wren, 1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid_wren_after", bus.mem_wren, 0);
        checkOutput("mid_busy", bus.init_busy, 1);
        checkOutput("mid_drop", bus.drop_count, 0);
        checkOutput("mid_full", bus.up_full, 0);
        bus.up_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        @(negedge clk);
        sweepCheck("mid_sweep");
        nw = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.mem_wren === 1'b1) nw++;
            step();
        end
        checkOutput("mid_discarded", 64'(nw), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
